// File: rtl/bsg_locking_arb_rr_sched_pkg.sv
// Shared types and helpers for the round-robin locking packet scheduler.
package bsg_locking_arb_rr_pkg;

    typedef enum logic {IDLE, LOCKED} state_e;

    function automatic int unsigned onehot_to_id(input logic [31:0] oh);
        int unsigned id;
        id = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) id = i;
        end
        return id;
    endfunction

endpackage

// File: rtl/bsg_locking_arb_rr_sched_pick.sv
// Combinational rotating-priority picker: first unmasked request at or above ptr_i, wrapping.
module bsg_rr_pick #(
    parameter int inputs_p = 16,
    localparam int lg_inputs_lp = $clog2(inputs_p)
) (
    input  logic [inputs_p-1:0]     reqs_i,
    input  logic [lg_inputs_lp-1:0] ptr_i,
    input  logic [inputs_p-1:0]     mask_i,
    output logic [inputs_p-1:0]     grant_oh_o,
    output logic [lg_inputs_lp-1:0] grant_id_o,
    output logic                    v_o
);

    logic [lg_inputs_lp:0] idx;

    always_comb begin
        grant_oh_o = '0;
        grant_id_o = '0;
        v_o        = 1'b0;
        idx        = '0;
        for (int unsigned off = 0; off < inputs_p; off++) begin
            idx = {1'b0, ptr_i} + (lg_inputs_lp+1)'(off);
            if (idx >= (lg_inputs_lp+1)'(inputs_p))
                idx = idx - (lg_inputs_lp+1)'(inputs_p);
            if (!v_o && reqs_i[idx[lg_inputs_lp-1:0]] && !mask_i[idx[lg_inputs_lp-1:0]]) begin
                v_o        = 1'b1;
                grant_id_o = idx[lg_inputs_lp-1:0];
            end
        end
        grant_oh_o[grant_id_o] = v_o;
    end

endmodule

// File: rtl/bsg_locking_arb_rr_sched.sv
// Round-robin locking packet scheduler; BSG_LOCKING_ARB_RR_TIMEOUT_EN adds a lock hold timeout.
module bsg_locking_arb_rr_sched
    import bsg_locking_arb_rr_pkg::*;
#(
    parameter int inputs_p = 16,
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
    parameter int max_hold_p = 256,
`endif
    localparam int lg_inputs_lp = $clog2(inputs_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [inputs_p-1:0]     reqs_i,
    input  logic [inputs_p-1:0]     last_i,
    input  logic                    ready_i,
    output logic [inputs_p-1:0]     grants_o,
    output logic [lg_inputs_lp-1:0] grant_id_o,
    output logic                    locked_o,
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
    output logic                    timeout_err_o,
`endif
    output logic                    xfer_o
);

    state_e                  state;
    logic [lg_inputs_lp-1:0] ptr, next_ptr, pick_ptr, pick_id;
    logic [inputs_p-1:0]     pick_mask, pick_oh;
    logic                    pick_v, last_rel, rel;

    assign xfer_o   = locked_o & reqs_i[grant_id_o] & ready_i;
    assign last_rel = xfer_o & last_i[grant_id_o];
    assign next_ptr = (grant_id_o == lg_inputs_lp'(inputs_p-1)) ? '0 : grant_id_o + lg_inputs_lp'(1);

`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
    localparam int cnt_w_lp = $clog2(max_hold_p+1);
    logic [cnt_w_lp-1:0] hold_cnt;
    logic                hold_expired;
    assign hold_expired = locked_o && (hold_cnt == cnt_w_lp'(max_hold_p-1));
    assign rel          = last_rel | hold_expired;
`else
    assign rel = last_rel;
`endif

    // One picker serves both the idle pick and the same-cycle release re-arbitration.
    assign pick_ptr  = (state == LOCKED) ? next_ptr : ptr;
    assign pick_mask = (state == LOCKED) ? grants_o : '0;

    bsg_rr_pick #(.inputs_p(inputs_p)) pick (
        .reqs_i    (reqs_i),
        .ptr_i     (pick_ptr),
        .mask_i    (pick_mask),
        .grant_oh_o(pick_oh),
        .grant_id_o(pick_id),
        .v_o       (pick_v)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            grants_o   <= '0;
            grant_id_o <= '0;
            locked_o   <= 1'b0;
            ptr        <= '0;
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
            hold_cnt      <= '0;
            timeout_err_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_v) begin
                        state      <= LOCKED;
                        grants_o   <= pick_oh;
                        grant_id_o <= pick_id;
                        locked_o   <= 1'b1;
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (rel) begin
                        ptr <= next_ptr;
                        if (pick_v) begin
                            grants_o   <= pick_oh;
                            grant_id_o <= pick_id;
                        end else begin
                            state      <= IDLE;
                            grants_o   <= '0;
                            grant_id_o <= '0;
                            locked_o   <= 1'b0;
                        end
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
                        hold_cnt <= '0;
                        if (!last_rel) timeout_err_o <= 1'b1;
`endif
                    end
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + cnt_w_lp'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_locking_arb_rr_sched.sv
// Directed bench for bsg_locking_arb_rr_sched with a grant-order scoreboard; covers BSG_LOCKING_ARB_RR_TIMEOUT_EN when defined.
module tb_bsg_locking_arb_rr_sched;
    import bsg_locking_arb_rr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] reqs, last;
    logic        ready;
    logic [15:0] grants;
    logic [3:0]  grant_id;
    logic        locked, xfer;
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
    logic        terr;
    localparam int stall_lp = 5;
`else
    localparam int stall_lp = 10;
`endif

    int          tests = 0, fails = 0;
    int          rem[16];
    int          plen = 1;
    bit          reload = 1'b0;
    int          nx = 0;
    bit          prev_locked = 1'b0;
    int          prev_id = 0;
    int unsigned exp_q[$];

    bsg_locking_arb_rr_sched #(
        .inputs_p(16)
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
        , .max_hold_p(8)
`endif
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .reqs_i    (reqs),
        .last_i    (last),
        .ready_i   (ready),
        .grants_o  (grants),
        .grant_id_o(grant_id),
        .locked_o  (locked),
`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
        .timeout_err_o(terr),
`endif
        .xfer_o    (xfer)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 16; i++) begin
            reqs[i] = (rem[i] != 0);
            last[i] = (rem[i] == 1);
        end
    endtask

    // Requester model: mid-cycle checks of new grants against the scoreboard, then beat accounting after the edge.
    task automatic tick();
        bit          x;
        int          o;
        int unsigned e;
        @(negedge clk);
        x = xfer;
        o = int'(grant_id);
        if (xfer) nx++;
        if (locked && (!prev_locked || int'(grant_id) != prev_id)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(grant_id), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk("grant_id", 32'(grant_id), e);
                chk("grant_oh", 32'(onehot_to_id(32'(grants))), e);
                chk("grants", 32'(grants), 32'(1) << e);
            end
        end
        prev_locked = locked;
        prev_id     = int'(grant_id);
        @(posedge clk);
        #1;
        if (x && rem[o] > 0) begin
            rem[o]--;
            if (rem[o] == 0 && reload) rem[o] = plen;
        end
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (locked && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(locked), 32'(0));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) rem[i] = 0;
        rst_n = 1'b0;
        ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grants", 32'(grants), 32'(0));
        chk("rst_id", 32'(grant_id), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_xfer", 32'(xfer), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'(locked), 32'(0));

        // 4-beat packet from requester 3
        rem[3] = 4; exp_q.push_back(3); nx = 0; drive();
        tick();
        chk("t1_locked", 32'(locked), 32'(1));
        chk("t1_grants", 32'(grants), 32'h0008);
        chk("t1_id", 32'(grant_id), 32'(3));
        run_idle(20);
        chk("t1_beats", 32'(nx), 32'(4));

        // pointer at 4: order 4, 15, 0 with no bubbles
        rem[4] = 1; rem[15] = 1; rem[0] = 1;
        exp_q.push_back(4); exp_q.push_back(15); exp_q.push_back(0);
        nx = 0; drive();
        tick();
        repeat (3) tick();
        chk("t2_beats", 32'(nx), 32'(3));
        chk("t2_idle", 32'(locked), 32'(0));
        chk("t2_q", 32'(exp_q.size()), 32'(0));

        // stall owner 2 while 5 waits
        rem[2] = 1; rem[5] = 1; exp_q.push_back(2); exp_q.push_back(5);
        nx = 0; drive();
        tick();
        ready = 1'b0;
        repeat (stall_lp) tick();
        chk("t3_stall_beats", 32'(nx), 32'(0));
        chk("t3_hold", 32'(grants), 32'h0004);
        ready = 1'b1;
        tick();
        chk("t3_next_id", 32'(grant_id), 32'(5));
        chk("t3_next_locked", 32'(locked), 32'(1));
        tick();
        chk("t3_beats", 32'(nx), 32'(2));
        chk("t3_idle", 32'(locked), 32'(0));

        // all 16 requesting continuously, 2-beat packets, starting at pointer 6
        plen = 2; reload = 1'b1; nx = 0;
        for (int i = 0; i < 16; i++) rem[i] = 2;
        for (int k = 0; k <= 32; k++) exp_q.push_back(32'((6 + k) % 16));
        drive();
        repeat (65) tick();
        reload = 1'b0;
        for (int i = 0; i < 16; i++) if (i != 6) rem[i] = 0;
        drive();
        run_idle(10);
        chk("t4_q", 32'(exp_q.size()), 32'(0));
        chk("t4_beats", 32'(nx), 32'(66));

        // reset mid-packet (owner 7, beat 2 of 4)
        rem[7] = 4; exp_q.push_back(7); drive();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_grants", 32'(grants), 32'(0));
        chk("t5_async_locked", 32'(locked), 32'(0));
        chk("t5_async_id", 32'(grant_id), 32'(0));
        chk("t5_async_xfer", 32'(xfer), 32'(0));
        rem[7] = 0; drive();
        prev_locked = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t5_rst_hold", 32'(locked), 32'(0));
        rem[7] = 1; rem[3] = 1; exp_q.push_back(3); exp_q.push_back(7); drive();
        tick();
        chk("t5_ptr_restart", 32'(grant_id), 32'(3));
        run_idle(10);
        chk("t5_q", 32'(exp_q.size()), 32'(0));

`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
        // owner 1 never finishes; forced release after 8 locked cycles
        chk("t6_err_pre", 32'(terr), 32'(0));
        rem[1] = 100; rem[4] = 1; exp_q.push_back(1); exp_q.push_back(4); drive();
        tick();
        n = 0;
        while (locked && grant_id == 4'd1 && n < 20) begin
            n++;
            tick();
        end
        chk("t6_hold_cycles", 32'(n), 32'(8));
        chk("t6_err", 32'(terr), 32'(1));
        chk("t6_next_id", 32'(grant_id), 32'(4));
        rem[1] = 0; drive();
        run_idle(10);
        chk("t6_err_sticky", 32'(terr), 32'(1));
        chk("t6_q", 32'(exp_q.size()), 32'(0));
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_locking_arb_rr_sched.md
Name: bsg_locking_arb_rr_sched

Overview:
Round-robin packet scheduler that shares one downstream resource (a channel or port) among inputs_p requesters. A winner is locked in until its last beat is accepted downstream, then ownership passes to the next requester in rotating priority. It sits between the requester queues and the shared resource, as the fair multi-beat counterpart to the fixed-priority locking arbiter.

Parameters:
inputs_p, 16, number of requesters (>=2)
lg_inputs_lp, $clog2(inputs_p), width of owner id (localparam)
max_hold_p, 256, maximum cycles one lock may last; used only with the timeout feature

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
reqs_i  in  inputs_p  per-requester "has beat" request
last_i  in  inputs_p  per-requester "current beat is the last of its packet"
ready_i  in  1  downstream accepts a beat this cycle
grants_o  out  inputs_p  one-hot current owner; registered; all-zero when idle
grant_id_o  out  lg_inputs_lp  binary id of the owner; valid when locked_o=1
locked_o  out  1  an owner holds the resource
xfer_o  out  1  beat transferred this cycle: locked_o & reqs_i[owner] & ready_i

Behaviour:
- One clock. Reset is asynchronous and active-low; this is fixed. Assertion takes effect immediately, and deassertion is synchronous to clk_i.
- Reset values: state=IDLE, grants_o=0, grant_id_o=0, locked_o=0, rr pointer=0, timeout error=0. xfer_o=0 follows from locked_o=0.
- State machine has two states, IDLE and LOCKED.
- IDLE, any reqs_i bit set:
  - Pick the first requester at or above the pointer, wrapping from inputs_p-1 to 0.
  - Register the pick as owner and go to LOCKED.
  - Grant latency is 1 cycle from the request. No beat transfers in IDLE.
- LOCKED:
  - A beat transfers when xfer_o=1.
  - If xfer_o=1 and last_i[owner]=1, the lock is released.
  - If reqs_i[owner] drops while locked, no transfer happens and the lock holds.
  - Requests from non-owners are ignored and no other grant is issued.
- Release cycle:
  - pointer <= owner+1, wrapping mod inputs_p.
  - Arbitrate in the same cycle over reqs_i with the releasing owner masked, starting from the new pointer.
  - If there is a winner, it owns the resource in the next cycle with no bubble; state stays LOCKED.
  - If there is no winner, go to IDLE.
  - A releasing owner that still requests competes again at the next arbitration.
- Single-beat packet: the beat with last_i=1 on the first locked cycle transfers and releases in that cycle.
- ready_i=0 stalls; owner and pointer are held indefinitely unless the timeout feature is enabled.
- last_i is sampled only for the owner, and only when xfer_o=1.
- Reset asserted mid-packet: the lock is dropped immediately and all outputs go to their reset values. A packet that was in flight is the requester's responsibility.
- Requesters must hold reqs_i and beat data stable until the beat is accepted. After their last beat is accepted they must deassert reqs_i, unless they have another packet.

Optional Feature:
Macro BSG_LOCKING_ARB_RR_TIMEOUT_EN.
- Defined:
  - Adds a hold counter of width $clog2(max_hold_p+1). It clears on every new lock and increments each LOCKED cycle.
  - When the counter reaches max_hold_p-1 with no release, the lock is force-released and treated as a normal release (pointer advances, same-cycle re-arbitration).
  - Adds output timeout_err_o (1 bit), sticky until reset.
- Not defined: no counter and no timeout_err_o port; a lock persists until last.

Decomposition:
- Package bsg_locking_arb_rr_pkg:
  - enum state_e {IDLE, LOCKED}.
  - Function onehot_to_id, for use by the bench scoreboard.
- Sub-module bsg_rr_pick (combinational), parameter inputs_p:
  - Inputs: reqs_i, ptr_i, mask_i.
  - Outputs: grant_oh_o, grant_id_o, v_o.
  - Instantiated once; its output drives next-owner on the IDLE pick and on the release pick.

Test Plan:
- Reset, then reqs_i=0x0008 -> locked_o=1, grants_o=0x0008, grant_id_o=3 on the next cycle. With ready_i=1 and 4 beats, last on beat 4 -> xfer_o pulses 4 cycles, then IDLE with pointer=4.
- Pointer=4 and reqs_i=0x8011 at release -> grant order 4, 15, 0, each a 1-beat packet, zero bubbles between packets.
- Owner 2 with ready_i=0 for 10 cycles -> xfer_o=0 and grants_o=0x0004 held. ready_i=1 with last -> release, and requester 5 requesting since cycle 0 gets its grant the next cycle.
- All 16 request continuously with 2-beat packets -> each id granted exactly once per 16 packets, in ascending wrapped order.
- reset_n_i pulsed low mid-packet (owner 7, beat 2 of 4) -> outputs 0 asynchronously; after release, reqs_i=0x0080 -> fresh grant to 7 with pointer restarted at 0.
- BSG_LOCKING_ARB_RR_TIMEOUT_EN, max_hold_p=8, owner 1 never asserts last -> release after 8 locked cycles, timeout_err_o=1 sticky, next requester granted.
